// File: rtl/isp_binary_gen.sv
// rtl/isp_binary_gen.sv - RGB565 to 1-bit binary stream with fixed or adaptive luma threshold

module isp_binary_gen #(
  parameter logic [10:0] H_PIXEL    = 11'd960,
  parameter logic [9:0]  V_PIXEL    = 10'd540,
  parameter logic [7:0]  FIX_THRESH = 8'd128,
  parameter logic        INV        = 1'b0
) (
  input  logic        vtc_clk,
  input  logic        vtc_rstn,
  input  logic        pre_hs,
  input  logic        pre_vs,
  input  logic        pre_wr_en,
  input  logic [15:0] pre_rgb565,
  input  logic        thresh_mode,
  output logic        isp_href,
  output logic        isp_vsync,
  output logic        isp_wr_en,
  output logic        isp_1bit_out,
  output logic [15:0] syn_data,
  output logic [7:0]  cur_thresh,
  output logic        frame_done
);

  // Guard the pixel counter against wrap when the nominal frame fills a large share of its range.
  localparam bit L_CNT_GUARD = (32'(H_PIXEL) * 32'(V_PIXEL)) > 32'h0003_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  // Pipeline registers
  logic [15:0] r_prod_r, r_prod_g, r_prod_b;
  logic [17:0] r_sum;
  logic [2:0]  r_hs_sr, r_vs_sr, r_we_sr;
  logic [15:0] r_rgb_d1, r_rgb_d2, r_rgb_d3;
  logic        r_bit;

  // Statistics, divider and threshold state
  logic [27:0] r_y_sum;
  logic [19:0] r_pix_cnt;
  logic [19:0] r_divisor;
  logic [19:0] r_rem;
  logic [27:0] r_quo;
  logic [4:0]  r_iter;
  logic        r_suppress;
  logic [7:0]  r_adaptive;
  logic [7:0]  r_cur_thresh;
  logic        r_frame_done;
  state_t      r_state;
  state_t      w_state_next;
  state_t      w_start_state;

  logic [7:0]  w_r8, w_g8, w_b8;
  logic [7:0]  w_y2;
  logic        w_we2;
  logic        w_vs_rise, w_vs_fall;
  logic [28:0] w_ysum_add;
  logic [27:0] w_ysum_next;
  logic        w_cnt_full;
  logic [20:0] w_rem_sh;
  logic [20:0] w_rem_sub;
  logic        w_ge;
  logic        w_unused;

  assign w_r8 = {pre_rgb565[15:11], pre_rgb565[15:13]};
  assign w_g8 = {pre_rgb565[10:5],  pre_rgb565[10:9]};
  assign w_b8 = {pre_rgb565[4:0],   pre_rgb565[4:2]};

  assign w_y2      = r_sum[15:8];
  assign w_we2     = r_we_sr[1];
  assign w_unused  = ^{r_sum[17:16], r_sum[7:0]};

  // Edges are taken against the first stage of the vs delay line.
  assign w_vs_rise = pre_vs & ~r_vs_sr[0];
  assign w_vs_fall = ~pre_vs & r_vs_sr[0];

  assign w_ysum_add  = {1'b0, r_y_sum} + {21'd0, w_y2};
  assign w_ysum_next = w_ysum_add[28] ? 28'hFFF_FFFF : w_ysum_add[27:0];
  assign w_cnt_full  = L_CNT_GUARD & (&r_pix_cnt);

  assign w_rem_sh  = {r_rem, r_quo[27]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_divisor};
  assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});

  assign w_start_state = (r_pix_cnt == 20'd0) ? S_DONE : S_DIV;

  // Luma products, sum and binarisation plus the matching 3-stage control/data delay.
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_prod_r <= '0;
      r_prod_g <= '0;
      r_prod_b <= '0;
      r_sum    <= '0;
      r_hs_sr  <= '0;
      r_vs_sr  <= '0;
      r_we_sr  <= '0;
      r_rgb_d1 <= '0;
      r_rgb_d2 <= '0;
      r_rgb_d3 <= '0;
      r_bit    <= 1'b0;
    end else begin
      r_prod_r <= 16'd77  * {8'd0, w_r8};
      r_prod_g <= 16'd150 * {8'd0, w_g8};
      r_prod_b <= 16'd29  * {8'd0, w_b8};
      r_sum    <= {2'b00, r_prod_r} + {2'b00, r_prod_g} + {2'b00, r_prod_b};
      r_hs_sr  <= {r_hs_sr[1:0], pre_hs};
      r_vs_sr  <= {r_vs_sr[1:0], pre_vs};
      r_we_sr  <= {r_we_sr[1:0], pre_wr_en};
      r_rgb_d1 <= pre_rgb565;
      r_rgb_d2 <= r_rgb_d1;
      r_rgb_d3 <= r_rgb_d2;
      r_bit    <= w_we2 & ((w_y2 > r_cur_thresh) ^ INV);
    end
  end

  // Per-frame luma sum and pixel count; a vs rise hands them to the divider and restarts them.
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_y_sum   <= '0;
      r_pix_cnt <= '0;
    end else if (w_vs_rise) begin
      r_y_sum   <= w_we2 ? {20'd0, w_y2} : 28'd0;
      r_pix_cnt <= w_we2 ? 20'd1 : 20'd0;
    end else if (w_we2) begin
      r_y_sum   <= w_ysum_next;
      if (!w_cnt_full) begin
        r_pix_cnt <= r_pix_cnt + 20'd1;
      end
    end
  end

  // Restoring divider: latch on vs rise (which also aborts a running division), one bit per cycle.
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_iter     <= '0;
      r_suppress <= 1'b0;
    end else if (w_vs_rise) begin
      r_divisor  <= r_pix_cnt;
      r_rem      <= '0;
      r_quo      <= r_y_sum;
      r_iter     <= '0;
      r_suppress <= (r_pix_cnt == 20'd0);
    end else if (r_state == S_DIV) begin
      r_rem  <= w_ge ? w_rem_sub[19:0] : w_rem_sh[19:0];
      r_quo  <= {r_quo[26:0], w_ge};
      r_iter <= r_iter + 5'd1;
    end
  end

  // State register, done pulse, adaptive result and frame-boundary threshold commit.
  always_ff @(posedge vtc_clk or negedge vtc_rstn) begin
    if (!vtc_rstn) begin
      r_state      <= S_IDLE;
      r_frame_done <= 1'b0;
      r_adaptive   <= FIX_THRESH;
      r_cur_thresh <= FIX_THRESH;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= (w_state_next == S_DONE);
      if ((r_state == S_DONE) && !r_suppress) begin
        r_adaptive <= (|r_quo[27:8]) ? 8'hFF : r_quo[7:0];
      end
      if (w_vs_fall) begin
        r_cur_thresh <= thresh_mode ? r_adaptive : FIX_THRESH;
      end
    end
  end

  // Next state: any vs rise (re)starts the mean computation.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_vs_rise) w_state_next = w_start_state;
      end
      S_DIV: begin
        if (w_vs_rise)               w_state_next = w_start_state;
        else if (r_iter == 5'd27)    w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_vs_rise) w_state_next = w_start_state;
        else           w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign isp_href     = r_hs_sr[2];
  assign isp_vsync    = r_vs_sr[2];
  assign isp_wr_en    = r_we_sr[2];
  assign isp_1bit_out = r_bit;
  assign syn_data     = r_rgb_d3;
  assign cur_thresh   = r_cur_thresh;
  assign frame_done   = r_frame_done;

endmodule
